ym3438_write_arbiter: RTL and testbench
=======================================

# ym3438_write_arbiter

Host-side write sequencer for the YM3438 bus interface. Two requesters (e.g. 68k and Z80 sides) post register writes as {bank, register address, data}. The block arbitrates between them round-robin and drives the chip's CS_n/WR_n/A1/A0/D[7:0] pins through an address-write phase and then a data-write phase. It then blocks further writes for a fixed busy window that covers the chip's internal busy counter, so no write is ever issued while the chip would ignore it.

## Interface
Parameters:
- WR_LEN, 4: MCLK cycles CS_n/WR_n held low per phase (1..65535)
- HOLD_LEN, 2: MCLK cycles after each strobe with CS_n/WR_n high and bus held stable (1..65535)
- BUSY_LEN, 192: MCLK cycles waited after the data phase before the next grant (1..65535)

Ports:
- MCLK  in  1  clock; everything is synchronous to its rising edge
- reset  in  1  synchronous, active-high reset
- req0 / req1  in  1  write request, held high with stable fields until the matching ack
- bank0 / bank1  in  1  register bank, driven onto A1
- addr0 / addr1  in  8  register address
- data0 / data1  in  8  register data
- ack0 / ack1  out  1  one-cycle pulse; the request has been captured and its fields may change
- bus_cs_n  out  1  chip select, active low
- bus_wr_n  out  1  write strobe, active low
- bus_address  out  2  {A1, A0}
- bus_data  out  8  chip data bus
- active  out  1  high in every state except IDLE
- last_grant  out  1  index of the most recently granted port

## Operation
- States: IDLE, A_STB, A_HOLD, D_STB, D_HOLD, WAIT. A single 16-bit down-counter times every non-IDLE state.
- IDLE, arbitration at each edge:
  - only one req high: grant that port.
  - both high: grant port ~last_grant.
  - neither high: stay in IDLE.
- On grant:
  - capture bank, addr and data into internal registers.
  - set last_grant to the granted index.
  - pulse ack for that port in the next cycle (registered).
  - enter A_STB with counter = WR_LEN-1.
- Each timed state exits when its counter is 0 and reloads the counter for the next state:
  - A_STB → A_HOLD (HOLD_LEN)
  - A_HOLD → D_STB (WR_LEN)
  - D_STB → D_HOLD (HOLD_LEN)
  - D_HOLD → WAIT (BUSY_LEN)
  - WAIT → IDLE
- Outputs by state:
  - A_STB: cs_n=0, wr_n=0, bus_address={bank,0}, bus_data=addr.
  - A_HOLD: cs_n=1, wr_n=1, bus_address and bus_data unchanged from A_STB.
  - D_STB: cs_n=0, wr_n=0, bus_address={bank,1}, bus_data=data.
  - D_HOLD: cs_n=1, wr_n=1, bus_address and bus_data unchanged from D_STB.
  - IDLE and WAIT: cs_n=1, wr_n=1, bus_address=0, bus_data=0.
- All bus outputs are registered, so there are no glitches on CS_n or WR_n.
- A request dropped before its ack is simply never granted; it is not an error.
- ack0 and ack1 are never high in the same cycle.

## Timing
- Reset values: state IDLE, cs_n=1, wr_n=1, bus_address=0, bus_data=0, ack0=ack1=0, active=0, last_grant=1 (port 0 wins the first tie).
- Reset asserted mid-transaction:
  - at the next edge all outputs take their reset values.
  - the captured write is discarded and no ack is issued for it.
  - a request that was already acked is not retried.
- Grant latency: req is sampled high in IDLE at edge E. At E+1, ack is high, state is A_STB and cs_n=wr_n=0.
- Phase durations:
  - CS_n low for exactly WR_LEN cycles per phase.
  - gap between the address and data strobes is exactly HOLD_LEN cycles.
- Transaction length from the first A_STB cycle to the first IDLE cycle: 2·WR_LEN + 2·HOLD_LEN + BUSY_LEN cycles (204 with defaults).
- The minimum spacing between successive ack pulses is that length + 1 (205 with defaults).
- bus_address and bus_data are stable for the whole strobe and through HOLD_LEN cycles after wr_n rises.
- Parameter value 1 gives a single-cycle state; a value of 0 is illegal.

## Test plan
- Single write, defaults, port 0 {bank=1, addr=0x28, data=0xF0}:
  - ack0 pulses one cycle after req.
  - cs_n/wr_n low 4 cycles with bus_address=2'b10, bus_data=0x28.
  - 2 cycles high, then low 4 cycles with bus_address=2'b11, bus_data=0xF0.
  - active for 204 cycles.
- Both ports request continuously from reset:
  - grants alternate 0,1,0,1.
  - ack pulses are spaced 205 cycles apart.
  - ack0 and ack1 never overlap.
- Port 1 only, held continuously: repeated grants to port 1 with no dead grants while last_grant=1.
- Reset asserted during D_STB: next cycle cs_n=wr_n=1, bus=0, active=0; a subsequent request to port 0 is granted first.
- WR_LEN=1, HOLD_LEN=1, BUSY_LEN=1:
  - each strobe is a single cycle.
  - the transaction is 5 cycles.
  - back-to-back acks are 6 cycles apart.
- Fields changed on the cycle after ack: the bus still carries the captured values for the whole transaction.

Source files
------------

// File: rtl/ym3438_write_arbiter.sv
// Round-robin write sequencer for the YM3438 host bus: address phase, data phase,
// then a fixed busy window before the next grant. All pin outputs are registered.
module ym3438_write_arbiter #(
   parameter int WR_LEN   = 4,
   parameter int HOLD_LEN = 2,
   parameter int BUSY_LEN = 192
) (
   input  logic       MCLK,
   input  logic       reset,
   input  logic       req0,
   input  logic       req1,
   input  logic       bank0,
   input  logic       bank1,
   input  logic [7:0] addr0,
   input  logic [7:0] addr1,
   input  logic [7:0] data0,
   input  logic [7:0] data1,
   output logic       ack0,
   output logic       ack1,
   output logic       bus_cs_n,
   output logic       bus_wr_n,
   output logic [1:0] bus_address,
   output logic [7:0] bus_data,
   output logic       active,
   output logic       last_grant
);

   localparam logic [15:0] WR_LOAD   = 16'(WR_LEN - 1);
   localparam logic [15:0] HOLD_LOAD = 16'(HOLD_LEN - 1);
   localparam logic [15:0] BUSY_LOAD = 16'(BUSY_LEN - 1);

   typedef enum logic [2:0] {IDLE, A_STB, A_HOLD, D_STB, D_HOLD, WAIT} state_t;

   state_t      state_q, state_d;
   logic [15:0] cnt_q, cnt_d;
   logic        bank_q;
   logic [7:0]  addr_q, data_q;
   logic        grant_valid, grant_idx;
   logic        nxt_bank;
   logic [7:0]  nxt_addr, nxt_data;
   logic        cs_d, wr_d;
   logic [1:0]  address_d;
   logic [7:0]  bus_data_d;

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      grant_valid = 1'b0;
      grant_idx   = last_grant;
      case (state_q)
         IDLE: begin
            if (req0 && req1) begin
               grant_valid = 1'b1;
               grant_idx   = ~last_grant;
            end else if (req0 || req1) begin
               grant_valid = 1'b1;
               grant_idx   = req1;
            end
            if (grant_valid) begin
               state_d = A_STB;
               cnt_d   = WR_LOAD;
            end
         end
         A_STB:  if (cnt_q == 16'd0) begin state_d = A_HOLD; cnt_d = HOLD_LOAD; end
                 else cnt_d = cnt_q - 16'd1;
         A_HOLD: if (cnt_q == 16'd0) begin state_d = D_STB;  cnt_d = WR_LOAD;   end
                 else cnt_d = cnt_q - 16'd1;
         D_STB:  if (cnt_q == 16'd0) begin state_d = D_HOLD; cnt_d = HOLD_LOAD; end
                 else cnt_d = cnt_q - 16'd1;
         D_HOLD: if (cnt_q == 16'd0) begin state_d = WAIT;   cnt_d = BUSY_LOAD; end
                 else cnt_d = cnt_q - 16'd1;
         WAIT:   if (cnt_q == 16'd0) begin state_d = IDLE;   cnt_d = 16'd0;     end
                 else cnt_d = cnt_q - 16'd1;
         default: begin
            state_d = IDLE;
            cnt_d   = 16'd0;
         end
      endcase
   end

   // The bus registers are loaded from the next state, so on a grant they must
   // see the incoming fields rather than the not-yet-updated capture registers.
   always_comb begin
      nxt_bank   = grant_valid ? (grant_idx ? bank1 : bank0) : bank_q;
      nxt_addr   = grant_valid ? (grant_idx ? addr1 : addr0) : addr_q;
      nxt_data   = grant_valid ? (grant_idx ? data1 : data0) : data_q;
      cs_d       = 1'b1;
      wr_d       = 1'b1;
      address_d  = 2'b00;
      bus_data_d = 8'h00;
      case (state_d)
         A_STB:  begin cs_d = 1'b0; wr_d = 1'b0; address_d = {nxt_bank, 1'b0}; bus_data_d = nxt_addr; end
         A_HOLD: begin address_d = {nxt_bank, 1'b0}; bus_data_d = nxt_addr; end
         D_STB:  begin cs_d = 1'b0; wr_d = 1'b0; address_d = {nxt_bank, 1'b1}; bus_data_d = nxt_data; end
         D_HOLD: begin address_d = {nxt_bank, 1'b1}; bus_data_d = nxt_data; end
         default: begin
            address_d  = 2'b00;
            bus_data_d = 8'h00;
         end
      endcase
   end

   always_ff @(posedge MCLK) begin
      if (reset) begin
         state_q     <= IDLE;
         cnt_q       <= 16'd0;
         bank_q      <= 1'b0;
         addr_q      <= 8'h00;
         data_q      <= 8'h00;
         last_grant  <= 1'b1;
         ack0        <= 1'b0;
         ack1        <= 1'b0;
         bus_cs_n    <= 1'b1;
         bus_wr_n    <= 1'b1;
         bus_address <= 2'b00;
         bus_data    <= 8'h00;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         bank_q      <= nxt_bank;
         addr_q      <= nxt_addr;
         data_q      <= nxt_data;
         if (grant_valid) last_grant <= grant_idx;
         ack0        <= grant_valid && !grant_idx;
         ack1        <= grant_valid && grant_idx;
         bus_cs_n    <= cs_d;
         bus_wr_n    <= wr_d;
         bus_address <= address_d;
         bus_data    <= bus_data_d;
      end
   end

   assign active = (state_q != IDLE);

endmodule

// File: tb/tb_ym3438_write_arbiter.sv
// Directed bench for ym3438_write_arbiter: default timing instance plus a
// 1/1/1 timing instance sharing the same host-side inputs.
module tb_ym3438_write_arbiter;

   logic       MCLK = 1'b0;
   logic       reset = 1'b1;
   logic       req0 = 1'b0, req1 = 1'b0;
   logic       bank0 = 1'b0, bank1 = 1'b0;
   logic [7:0] addr0 = 8'h00, addr1 = 8'h00, data0 = 8'h00, data1 = 8'h00;

   logic       d_ack0, d_ack1, d_cs_n, d_wr_n, d_active, d_last;
   logic [1:0] d_address;
   logic [7:0] d_data;
   logic       f_ack0, f_ack1, f_cs_n, f_wr_n, f_active, f_last;
   logic [1:0] f_address;
   logic [7:0] f_data;

   int errors = 0;
   int checks = 0;
   int cyc = 0;
   int ack_t[8];
   int ack_p[8];
   int ack_a[8];
   int ack_d[8];
   int nacks;
   int overlap;

   ym3438_write_arbiter dut (
      .MCLK(MCLK), .reset(reset), .req0(req0), .req1(req1), .bank0(bank0), .bank1(bank1),
      .addr0(addr0), .addr1(addr1), .data0(data0), .data1(data1),
      .ack0(d_ack0), .ack1(d_ack1), .bus_cs_n(d_cs_n), .bus_wr_n(d_wr_n),
      .bus_address(d_address), .bus_data(d_data), .active(d_active), .last_grant(d_last)
   );

   ym3438_write_arbiter #(.WR_LEN(1), .HOLD_LEN(1), .BUSY_LEN(1)) dut_fast (
      .MCLK(MCLK), .reset(reset), .req0(req0), .req1(req1), .bank0(bank0), .bank1(bank1),
      .addr0(addr0), .addr1(addr1), .data0(data0), .data1(data1),
      .ack0(f_ack0), .ack1(f_ack1), .bus_cs_n(f_cs_n), .bus_wr_n(f_wr_n),
      .bus_address(f_address), .bus_data(f_data), .active(f_active), .last_grant(f_last)
   );

   always #5 MCLK = ~MCLK;

   task automatic tick();
      @(posedge MCLK);
      #1;
      cyc++;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
         $error("check %s", tag);
      end
   endtask

   task automatic do_reset();
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
   endtask

   // Records up to n ack pulses from the selected instance within budget cycles.
   task automatic collect(input bit fast, input int n, input int budget);
      logic a0, a1;
      nacks   = 0;
      overlap = 0;
      for (int i = 0; i < budget && nacks < n; i++) begin
         tick();
         a0 = fast ? f_ack0 : d_ack0;
         a1 = fast ? f_ack1 : d_ack1;
         if (a0 && a1) overlap++;
         if (a0 || a1) begin
            ack_t[nacks] = cyc;
            ack_p[nacks] = a1 ? 1 : 0;
            ack_a[nacks] = fast ? int'(f_address) : int'(d_address);
            ack_d[nacks] = fast ? int'(f_data) : int'(d_data);
            nacks++;
         end
      end
      chk("ack_count_within_budget", nacks, n);
      chk("ack_no_overlap", overlap, 0);
   endtask

   initial begin
      logic [1:0] exp_a;
      logic [7:0] exp_d;
      logic       exp_cs;
      logic [1:0] f_exp_a[6];
      logic       f_exp_cs[6];
      logic       f_exp_act[6];

      // Reset values
      do_reset();
      chk("rst_cs_n", d_cs_n, 1);
      chk("rst_wr_n", d_wr_n, 1);
      chk("rst_address", d_address, 0);
      chk("rst_data", d_data, 0);
      chk("rst_ack0", d_ack0, 0);
      chk("rst_ack1", d_ack1, 0);
      chk("rst_active", d_active, 0);
      chk("rst_last_grant", d_last, 1);

      // Single write from port 0; fields change right after ack
      req0 = 1'b1; bank0 = 1'b1; addr0 = 8'h28; data0 = 8'hF0;
      tick();
      chk("t1_ack0", d_ack0, 1);
      chk("t1_ack1", d_ack1, 0);
      chk("t1_last_grant", d_last, 0);
      req0 = 1'b0; bank0 = 1'b0; addr0 = 8'h55; data0 = 8'h11;
      for (int k = 0; k < 204; k++) begin
         if (k > 0) begin
            tick();
            chk("t1_ack0_low", d_ack0, 0);
         end
         exp_cs = !((k < 4) || (k >= 6 && k < 10));
         if (k < 6) begin exp_a = 2'b10; exp_d = 8'h28; end
         else if (k < 12) begin exp_a = 2'b11; exp_d = 8'hF0; end
         else begin exp_a = 2'b00; exp_d = 8'h00; end
         chk($sformatf("t1_cs_n_k%0d", k), d_cs_n, exp_cs);
         chk($sformatf("t1_wr_n_k%0d", k), d_wr_n, exp_cs);
         chk($sformatf("t1_address_k%0d", k), d_address, exp_a);
         chk($sformatf("t1_data_k%0d", k), d_data, exp_d);
         chk($sformatf("t1_active_k%0d", k), d_active, 1);
      end
      tick();
      chk("t1_idle_active", d_active, 0);
      chk("t1_idle_cs_n", d_cs_n, 1);

      // Both ports requesting from reset: alternate 0,1,0,1 at 205-cycle spacing
      reset = 1'b1;
      req0 = 1'b1; bank0 = 1'b0; addr0 = 8'h30; data0 = 8'h71;
      req1 = 1'b1; bank1 = 1'b1; addr1 = 8'hA4; data1 = 8'h22;
      tick();
      reset = 1'b0;
      collect(1'b0, 4, 1000);
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("t2_port_%0d", i), ack_p[i], i % 2);
         chk($sformatf("t2_addr_%0d", i), ack_a[i], (i % 2) ? 2 : 0);
         chk($sformatf("t2_data_%0d", i), ack_d[i], (i % 2) ? 8'hA4 : 8'h30);
      end
      for (int i = 0; i < 3; i++)
         chk($sformatf("t2_spacing_%0d", i), ack_t[i+1] - ack_t[i], 205);

      // Port 1 only, held continuously
      req0 = 1'b0;
      do_reset();
      collect(1'b0, 3, 1000);
      for (int i = 0; i < 3; i++) chk($sformatf("t3_port_%0d", i), ack_p[i], 1);
      for (int i = 0; i < 2; i++)
         chk($sformatf("t3_spacing_%0d", i), ack_t[i+1] - ack_t[i], 205);

      // Reset during D_STB, then a tie must go to port 0
      req1 = 1'b1;
      do_reset();
      tick();
      chk("t4_ack1", d_ack1, 1);
      req1 = 1'b0;
      for (int k = 1; k <= 7; k++) tick();
      chk("t4_in_dstb_cs_n", d_cs_n, 0);
      chk("t4_in_dstb_address", d_address, 2'b11);
      reset = 1'b1;
      tick();
      chk("t4_rst_cs_n", d_cs_n, 1);
      chk("t4_rst_wr_n", d_wr_n, 1);
      chk("t4_rst_address", d_address, 0);
      chk("t4_rst_data", d_data, 0);
      chk("t4_rst_active", d_active, 0);
      chk("t4_rst_last_grant", d_last, 1);
      reset = 1'b0;
      req0 = 1'b1; req1 = 1'b1;
      tick();
      chk("t4_tie_ack0", d_ack0, 1);
      chk("t4_tie_ack1", d_ack1, 0);
      req0 = 1'b0; req1 = 1'b0;

      // Minimum timing instance: 5-cycle transaction, 6-cycle ack spacing
      f_exp_cs  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
      f_exp_act = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
      f_exp_a   = '{2'b10, 2'b10, 2'b11, 2'b11, 2'b00, 2'b00};
      do_reset();
      req0 = 1'b1; bank0 = 1'b1; addr0 = 8'h2B; data0 = 8'h80;
      tick();
      chk("t5_ack0", f_ack0, 1);
      for (int k = 0; k < 6; k++) begin
         if (k > 0) begin
            tick();
            chk($sformatf("t5_ack0_low_k%0d", k), f_ack0, 0);
         end
         chk($sformatf("t5_cs_n_k%0d", k), f_cs_n, f_exp_cs[k]);
         chk($sformatf("t5_active_k%0d", k), f_active, f_exp_act[k]);
         chk($sformatf("t5_address_k%0d", k), f_address, f_exp_a[k]);
      end
      tick();
      chk("t5_regrant_ack0", f_ack0, 1);
      req0 = 1'b0;

      req0 = 1'b1; req1 = 1'b1;
      do_reset();
      collect(1'b1, 4, 100);
      for (int i = 0; i < 4; i++) chk($sformatf("t5_port_%0d", i), ack_p[i], i % 2);
      for (int i = 0; i < 3; i++)
         chk($sformatf("t5_spacing_%0d", i), ack_t[i+1] - ack_t[i], 6);
      req0 = 1'b0; req1 = 1'b0;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
